acesso_memoria: RTL and testbench

//  Memory-access stage directly downstream of the address/ALU stage. Takes the 64-bit
//  ALU/effective-address result plus Rb store data, performs one load or store on the

---
 rtl/acesso_memoria.sv | 214 +++++++++++++++++++++
 tb/tb_acesso_memoria.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acesso_memoria.sv
// Memory-access stage: one load/store on the req/ack data bus or ALU pass-through, then a one-cycle writeback beat.
// Optional macro MEM_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYCLES cycles without ack.
module acesso_memoria #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mem_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] st_data,
  input  logic [RD_W-1:0]   rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign,
  output logic              err_timeout
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  localparam logic [1:0] OP_ALU    = 2'b00;
  localparam logic [1:0] OP_STORE  = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_BUBBLE = 2'b11;

  logic [1:0]        state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [DATA_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [RD_W-1:0]   rd_q,        rd_d;
  logic              wb_valid_q,  wb_valid_d;
  logic              wb_we_q,     wb_we_d;
  logic [RD_W-1:0]   wb_rd_q,     wb_rd_d;
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;
  logic              misalign_q,  misalign_d;
  logic              err_to_q,    err_to_d;
  logic              timeout_hit_s;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The limit is reached on the TIMEOUT_CYCLES-th ACCESS cycle without ack.
  always_comb begin
    timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d         = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (state_q == ST_ACCESS && !mem_ack && !timeout_hit_s) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Timeout counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  assign in_ready = (state_q == ST_IDLE);

  // Next-state and output computation for the IDLE/ACCESS/RESP sequence
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = wb_we_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    err_to_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          case (mem_op)
            OP_ALU: begin
              state_d    = ST_RESP;
              wb_valid_d = 1'b1;
              wb_we_d    = (rd != {RD_W{1'b0}});
              wb_rd_d    = rd;
              wb_data_d  = alu_res;
            end
            OP_STORE, OP_LOAD: begin
              rd_d = rd;
              if (alu_res[2:0] != 3'b000) begin
                state_d    = ST_RESP;
                wb_valid_d = 1'b1;
                wb_we_d    = 1'b0;
                wb_rd_d    = rd;
                wb_data_d  = {DATA_W{1'b0}};
                misalign_d = 1'b1;
              end else begin
                state_d     = ST_ACCESS;
                mem_req_d   = 1'b1;
                mem_we_d    = (mem_op == OP_STORE);
                mem_addr_d  = alu_res;
                mem_wdata_d = (mem_op == OP_STORE) ? st_data : {DATA_W{1'b0}};
              end
            end
            OP_BUBBLE: begin
              state_d = ST_IDLE;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // An ack on the limit cycle takes priority over the abort.
        if (mem_ack) begin
          state_d    = ST_RESP;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = !mem_we_q && (rd_q != {RD_W{1'b0}});
          wb_data_d  = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
        end else if (timeout_hit_s) begin
          state_d    = ST_RESP;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = 1'b0;
          wb_data_d  = {DATA_W{1'b0}};
          err_to_d   = 1'b1;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Pipeline state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {DATA_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rd_q        <= {RD_W{1'b0}};
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= {RD_W{1'b0}};
      wb_data_q   <= {DATA_W{1'b0}};
      misalign_q  <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      err_to_q    <= err_to_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_we       = wb_we_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign misalign    = misalign_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_acesso_memoria.sv
// Scoreboard bench for acesso_memoria: stimulus pushes expected writeback beats, a monitor pops and compares.
module tb_acesso_memoria;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mem_op;
  logic [63:0] alu_res;
  logic [63:0] st_data;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misalign;
  logic        err_timeout;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_wb_valid = 1'b0;

  acesso_memoria #(
    .DATA_W(64),
    .RD_W(5)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .alu_res(alu_res), .st_data(st_data), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] s, input logic [4:0] r);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    mem_op   = op;
    alu_res  = a;
    st_data  = s;
    rd       = r;
    tick();
    in_valid = 1'b0;
    mem_op   = 2'b11;
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] r, input logic [63:0] d,
                              input logic mis, input logic to);
    exp_t e;
    e.we = we; e.rd = r; e.data = d; e.mis = mis; e.to = to;
    return e;
  endfunction

  // Monitor: every writeback beat must match the oldest expected beat
  always @(negedge clk) begin
    if (wb_valid) begin
      chk("wb_pulse_single", {63'd0, prev_wb_valid}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("wb_unexpected_beat", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_we",       {63'd0, wb_we},       {63'd0, e.we});
        chk("wb_rd",       {59'd0, wb_rd},       {59'd0, e.rd});
        chk("wb_data",     wb_data,              e.data);
        chk("misalign",    {63'd0, misalign},    {63'd0, e.mis});
        chk("err_timeout", {63'd0, err_timeout}, {63'd0, e.to});
      end
    end else begin
      if (misalign || err_timeout) chk("pulse_without_wb_valid", 64'd1, 64'd0);
    end
    prev_wb_valid = wb_valid;
  end

  initial begin
    int hi;
    rst_n = 1'b0; in_valid = 1'b0; mem_op = 2'b11; alu_res = 64'd0; st_data = 64'd0;
    rd = 5'd0; mem_rdata = 64'd0; mem_ack = 1'b0;
    tick();
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("rst_mem_req",   {63'd0, mem_req},  64'd0);
    chk("rst_mem_addr",  mem_addr,          64'd0);
    chk("rst_wb_valid",  {63'd0, wb_valid}, 64'd0);
    chk("rst_wb_data",   wb_data,           64'd0);
    chk("rst_wb_rd",     {59'd0, wb_rd},    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: ALU pass-through, latency 1
    exp_q.push_back(mk(1'b1, 5'd3, 64'h10, 1'b0, 1'b0));
    issue(2'b00, 64'h10, 64'd0, 5'd3);
    @(negedge clk);
    chk("alu_latency1", {63'd0, wb_valid}, 64'd1);
    chk("alu_no_req",   {63'd0, mem_req},  64'd0);

    // 2: load with ack on the third ACCESS cycle
    exp_q.push_back(mk(1'b1, 5'd5, 64'hDEADBEEF, 1'b0, 1'b0));
    issue(2'b10, 64'h100, 64'hAAAA, 5'd5);
    @(negedge clk);
    chk("ld_req",      {63'd0, mem_req},  64'd1);
    chk("ld_we",       {63'd0, mem_we},   64'd0);
    chk("ld_addr",     mem_addr,          64'h100);
    chk("ld_wdata",    mem_wdata,         64'd0);
    chk("ld_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 64'hDEADBEEF;
    @(negedge clk);
    chk("ld_req_cycle3", {63'd0, mem_req}, 64'd1);
    chk("ld_no_wb_yet",  {63'd0, wb_valid}, 64'd0);
    tick();
    mem_ack = 1'b0; mem_rdata = 64'd0;
    @(negedge clk);
    chk("ld_req_dropped", {63'd0, mem_req}, 64'd0);
    chk("ld_wb_now",      {63'd0, wb_valid}, 64'd1);

    // bubble: nothing changes, wb_data holds
    issue(2'b11, 64'h999, 64'd0, 5'd1);
    @(negedge clk);
    chk("bubble_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bubble_wb_hold",  wb_data,           64'hDEADBEEF);
    chk("bubble_no_req",   {63'd0, mem_req},  64'd0);

    // 3: store with ack in the first ACCESS cycle
    exp_q.push_back(mk(1'b0, 5'd7, 64'd0, 1'b0, 1'b0));
    issue(2'b01, 64'h208, 64'h55, 5'd7);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("st_we",    {63'd0, mem_we}, 64'd1);
    chk("st_wdata", mem_wdata,       64'h55);
    chk("st_addr",  mem_addr,        64'h208);
    tick();
    mem_ack = 1'b0;

    // 3b: load to r0 writes nothing
    exp_q.push_back(mk(1'b0, 5'd0, 64'h1234, 1'b0, 1'b0));
    issue(2'b10, 64'h300, 64'd0, 5'd0);
    mem_ack = 1'b1; mem_rdata = 64'h1234;
    tick();
    mem_ack = 1'b0; mem_rdata = 64'd0;

    // 4: misaligned load and store, no bus activity
    exp_q.push_back(mk(1'b0, 5'd4, 64'd0, 1'b1, 1'b0));
    issue(2'b10, 64'h103, 64'd0, 5'd4);
    @(negedge clk);
    chk("mis_ld_no_req", {63'd0, mem_req}, 64'd0);
    exp_q.push_back(mk(1'b0, 5'd6, 64'd0, 1'b1, 1'b0));
    issue(2'b01, 64'h20C, 64'h77, 5'd6);
    @(negedge clk);
    chk("mis_st_no_req", {63'd0, mem_req}, 64'd0);

    // 5: reset in the middle of an access, late ack ignored
    issue(2'b10, 64'h400, 64'd0, 5'd9);
    #2;
    chk("pre_rst_req", {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req",      {63'd0, mem_req},  64'd0);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 64'hBAD;
    tick();
    mem_ack = 1'b0; mem_rdata = 64'd0;
    @(negedge clk);
    chk("late_ack_no_req",   {63'd0, mem_req},  64'd0);
    chk("late_ack_in_ready", {63'd0, in_ready}, 64'd1);

    // 6: no ack for a long time
`ifdef MEM_TIMEOUT_EN
    exp_q.push_back(mk(1'b0, 5'd2, 64'd0, 1'b0, 1'b1));
    issue(2'b10, 64'h500, 64'd0, 5'd2);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) hi++;
      tick();
    end
    chk("timeout_req_cycles", 64'(hi), 64'd8);
`else
    exp_q.push_back(mk(1'b1, 5'd2, 64'h77, 1'b0, 1'b0));
    issue(2'b10, 64'h500, 64'd0, 5'd2);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) hi++;
      tick();
    end
    chk("no_timeout_req_cycles", 64'(hi), 64'd20);
    mem_ack = 1'b1; mem_rdata = 64'h77;
    tick();
    mem_ack = 1'b0; mem_rdata = 64'd0;
`endif

    repeat (4) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
